// File: rtl/alu_mp_sequencer_if.sv
// alu_mp_sequencer_if: control-side request/result and ALU-side a/b/cin -> result/cout signals.
// Carries the overflow flag only when ALU_MP_SEQUENCER_OVERFLOW_EN is defined.
interface alu_mp_sequencer_if #(parameter int DATA_BITS = 8, parameter int WORDS = 4);
  localparam int W = DATA_BITS * WORDS;
  logic                 start;
  logic                 op_sub;
  logic [W-1:0]         opa;
  logic [W-1:0]         opb;
  logic                 busy;
  logic                 done;
  logic [W-1:0]         result;
  logic                 carry;
  logic                 zero;
  logic [DATA_BITS-1:0] alu_a;
  logic [DATA_BITS-1:0] alu_b;
  logic                 alu_cin;
  logic [DATA_BITS-1:0] alu_result;
  logic                 alu_cout;
`ifdef ALU_MP_SEQUENCER_OVERFLOW_EN
  logic                 overflow;
`endif
  modport master (
    output start, op_sub, opa, opb, alu_result, alu_cout,
    input  busy, done, result, carry, zero, alu_a, alu_b, alu_cin
`ifdef ALU_MP_SEQUENCER_OVERFLOW_EN
    , input overflow
`endif
  );
  modport slave (
    input  start, op_sub, opa, opb, alu_result, alu_cout,
    output busy, done, result, carry, zero, alu_a, alu_b, alu_cin
`ifdef ALU_MP_SEQUENCER_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/alu_mp_sequencer.sv
// alu_mp_sequencer: word-serial multi-precision add/sub driving a registered ALU, LSW first.
// Define ALU_MP_SEQUENCER_OVERFLOW_EN to add the signed overflow flag.
module alu_mp_sequencer #(
  parameter int DATA_BITS = 8,
  parameter int WORDS     = 4
) (
  input logic clk,
  input logic reset_n,
  alu_mp_sequencer_if.slave bus
);
  localparam int W  = DATA_BITS * WORDS;
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WORDS-1:0][DATA_BITS-1:0] a_q, a_d, b_q, b_d, work_q, work_d;
  logic sub_q, sub_d, c_q, c_d;
  logic [W-1:0] result_q, result_d;
  logic carry_q, carry_d, zero_q, zero_d;
  logic active, last;
  logic [DATA_BITS-1:0] x;
`ifdef ALU_MP_SEQUENCER_OVERFLOW_EN
  logic ovf_q, ovf_d;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      sub_q    <= 1'b0;
      c_q      <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
`ifdef ALU_MP_SEQUENCER_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      sub_q    <= sub_d;
      c_q      <= c_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
`ifdef ALU_MP_SEQUENCER_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end
  assign last = idx_q == IW'(WORDS - 1);
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    sub_d    = sub_q;
    c_d      = c_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
`ifdef ALU_MP_SEQUENCER_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        a_d     = bus.opa;
        b_d     = bus.opb;
        sub_d   = bus.op_sub;
        c_d     = bus.op_sub;
        idx_d   = '0;
        state_d = ISSUE;
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        work_d[idx_q] = bus.alu_result;
        c_d           = bus.alu_cout;
        idx_d         = last ? idx_q : idx_q + IW'(1);
        state_d       = last ? DONE : ISSUE;
        // Publish on the edge into DONE so the flags are valid alongside the done pulse.
        if (last) begin
          result_d = work_d;
          carry_d  = bus.alu_cout;
          zero_d   = work_d == '0;
`ifdef ALU_MP_SEQUENCER_OVERFLOW_EN
          ovf_d    = (a_q[WORDS-1][DATA_BITS-1] == (b_q[WORDS-1][DATA_BITS-1] ^ sub_q)) &&
                     (work_d[WORDS-1][DATA_BITS-1] != a_q[WORDS-1][DATA_BITS-1]);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // The ALU only offers a+b and a+~b+1, so a chained carry is folded in by inverting X.
  assign active      = state_q == ISSUE || state_q == CAPTURE;
  assign x           = sub_q ? ~b_q[idx_q] : b_q[idx_q];
  assign bus.alu_a   = active ? a_q[idx_q] : '0;
  assign bus.alu_b   = active ? (c_q ? ~x : x) : '0;
  assign bus.alu_cin = active & c_q;
  assign bus.busy    = active;
  assign bus.done    = state_q == DONE;
  assign bus.result  = result_q;
  assign bus.carry   = carry_q;
  assign bus.zero    = zero_q;
`ifdef ALU_MP_SEQUENCER_OVERFLOW_EN
  assign bus.overflow = ovf_q;
`endif
endmodule

// File: doc/alu_mp_sequencer.md
Name: alu_mp_sequencer

Overview:
Multi-precision add/subtract sequencer. Drives the registered DATA_BITS-wide ALU, one word per step, from the least significant word to the most significant word, and chains the carry between words. Turns a single start request into a WORDS*DATA_BITS-wide result with carry and zero flags. Sits between the control unit and the ALU. It is the requester side of the ALU's a/b/cin → result/cout interface.

Parameters:
DATA_BITS, 8, width of one ALU word
WORDS, 4, number of words per operand (must be ≥1); the full width is W = DATA_BITS*WORDS

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled only in IDLE
op_sub  input  1  0 = opa+opb, 1 = opa-opb; latched with start
opa  input  W  first operand; latched with start
opb  input  W  second operand; latched with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  single-cycle pulse when the result is updated
result  output  W  last completed result; held between operations
carry  output  1  final carry-out (for subtraction, 1 = no borrow)
zero  output  1  1 when all W bits of result are 0
alu_a  output  DATA_BITS  ALU operand a
alu_b  output  DATA_BITS  ALU operand b
alu_cin  output  1  ALU cin (1 selects a + ~b + 1)
alu_result  input  DATA_BITS  registered ALU result
alu_cout  input  1  registered ALU carry-out

Behaviour:
- Clock is clk. Reset is reset_n, asynchronous and active-low.
- Reset values: state=IDLE, index=0; busy, done, carry, zero = 0; result = 0; alu_a, alu_b, alu_cin = 0.
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE: if start=1, latch opa, opb and op_sub; set index=0; set chain carry c = op_sub; go to ISSUE. Otherwise stay in IDLE.
- ISSUE: drive the ALU inputs for word[index]. Go to CAPTURE.
- CAPTURE: the ALU inputs stay unchanged from ISSUE. The ALU output for word[index] is now valid. Store alu_result into the working word[index]. Set c = alu_cout. If index == WORDS-1, go to DONE. Otherwise increment index and go to ISSUE.
- DONE: copy the working result to result, set carry = c, set zero = (working result == 0), pulse done for one cycle, go to IDLE.
- Timing: start is accepted at edge E0. Then ISSUE/CAPTURE alternate for 2*WORDS cycles, and done is high during cycle 2*WORDS+1 after E0 (cycle 9 for WORDS=4). busy is high in ISSUE and CAPTURE and low in IDLE and DONE.
- Carry-chain encoding (the ALU has no add-with-carry mode):
  - Let X = opb_word for add, or ~opb_word for subtract; the wanted sum is a + X + c.
  - If c=0: drive alu_a = opa_word, alu_b = X, alu_cin = 0.
  - If c=1: drive alu_a = opa_word, alu_b = ~X, alu_cin = 1.
  - Arithmetic is modulo 2^DATA_BITS per word. alu_cout is the word's carry-out.
- In IDLE and DONE, alu_a, alu_b and alu_cin are driven to 0.
- start while busy or in DONE is ignored and does not queue. A start in the cycle right after DONE is accepted normally.
- Operands are captured at E0. Changes on opa, opb or op_sub after E0 have no effect on the running operation.
- result, carry and zero change only in DONE.
- reset_n deasserted mid-operation aborts immediately: no done pulse, and all outputs take their reset values.
- alu_zero is not used. zero is computed internally over all W bits.

Optional Feature:
Macro ALU_MP_SEQUENCER_OVERFLOW_EN.
- Defined: adds output port overflow (1 bit, reset 0), updated in DONE. It equals the signed two's-complement overflow of the W-bit operation: (opa[W-1] == Xmsb) && (result[W-1] != opa[W-1]), where Xmsb = opb[W-1] for add and ~opb[W-1] for subtract.
- Undefined: the port is absent and there is no overflow logic.

Test Plan:
1. WORDS=4, add 0x000000FF+0x00000001 → done at cycle 9 after start; result=0x00000100, carry=0, zero=0; busy high for cycles 1-8.
2. Add 0xFFFFFFFF+0x00000001 → result=0x00000000, carry=1, zero=1. Bench checks per-word alu_cin: 0, then 1, 1, 1.
3. Subtract 0x00000100-0x00000001 → result=0x000000FF, carry=1. Word0 drives alu_b=0x01 with alu_cin=1; word1 drives alu_b=0xFF with alu_cin=0.
4. Subtract 0x00000001-0x00000002 → result=0xFFFFFFFF, carry=0, zero=0.
5. Pulse start again on cycles 3 and 9 of a running add → ignored, exactly one done. Separately, reset_n low during cycle 4 → no done pulse, result=0, busy=0; a new add afterwards completes correctly.
6. With ALU_MP_SEQUENCER_OVERFLOW_EN: add 0x7FFFFFFF+0x00000001 → result=0x80000000, overflow=1. Subtract 0x80000000-0x00000001 → overflow=1. Add 0x00000001+0x00000001 → overflow=0.
